// File: rtl/traffic_pkg.sv
// Shared lamp codes, phase codes and default dwell constants for the intersection controller.
// Pure declarations; no timing or flow-control behaviour.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  typedef enum logic [2:0] {
    HG = 3'd0,
    HY = 3'd1,
    AR = 3'd2,
    CG = 3'd3,
    CY = 3'd4,
    PW = 3'd5
  } phase_t;

  localparam int DEF_Y2R_DELAY = 3;
  localparam int DEF_R2G_DELAY = 2;
  localparam int DEF_MIN_GREEN = 8;
  localparam int DEF_MAX_CNTRY = 10;
  localparam int DEF_PED_WALK  = 6;
  localparam int DEF_CNT_W     = 4;

  function automatic logic [1:0] hwy_lamp(input phase_t p);
    case (p)
      HG:      return GREEN;
      HY:      return YELLOW;
      default: return RED;
    endcase
  endfunction

  function automatic logic [1:0] cntry_lamp(input phase_t p);
    case (p)
      CG:      return GREEN;
      CY:      return YELLOW;
      default: return RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating dwell counter: clears on reset or restart, otherwise counts up and holds at all-ones.
// Count visible the cycle after each edge; no flow control.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             restart,
  output logic [CNT_W-1:0] t
);

  logic [CNT_W-1:0] r_t;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_t <= '0;
    end else if (restart) begin
      r_t <= '0;
    end else if (r_t != '1) begin
      r_t <= r_t + 1'b1;
    end
  end

  assign t = r_t;

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Counter-timed highway/country/pedestrian phase arbiter with emergency preempt to highway green.
// Moore outputs from registered phase and ped_wait; requests are held off only by dwell timers.
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int Y2R_DELAY = DEF_Y2R_DELAY,
  parameter int R2G_DELAY = DEF_R2G_DELAY,
  parameter int MIN_GREEN = DEF_MIN_GREEN,
  parameter int MAX_CNTRY = DEF_MAX_CNTRY,
  parameter int PED_WALK  = DEF_PED_WALK,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       clear_n,
  input  logic       x,
  input  logic       ped_req,
  input  logic       emg,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] Y2R_LAST  = CNT_W'(Y2R_DELAY - 1);
  localparam logic [CNT_W-1:0] R2G_LAST  = CNT_W'(R2G_DELAY - 1);
  localparam logic [CNT_W-1:0] MING_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAXC_LAST = CNT_W'(MAX_CNTRY - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(PED_WALK - 1);

  phase_t           r_state;
  phase_t           r_tgt;
  logic             r_ped_wait;
  phase_t           w_nxt;
  phase_t           w_nxt_tgt;
  logic             w_restart;
  logic [CNT_W-1:0] w_t;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock   (clock),
    .clear_n (clear_n),
    .restart (w_restart),
    .t       (w_t)
  );

  // Next phase is combinational so the timer restarts on the same edge the phase changes.
  always_comb begin
    w_nxt     = r_state;
    w_nxt_tgt = r_tgt;
    case (r_state)
      HG: if (!emg && (w_t >= MING_LAST) && (r_ped_wait || x)) begin
        w_nxt     = HY;
        w_nxt_tgt = r_ped_wait ? PW : CG;
      end
      HY: if (w_t == Y2R_LAST) w_nxt = AR;
      AR: if (w_t == R2G_LAST) w_nxt = emg ? HG : r_tgt;
      CG: if (!x || (w_t == MAXC_LAST) || emg) begin
        w_nxt     = CY;
        w_nxt_tgt = HG;
      end
      CY: if (w_t == Y2R_LAST) begin
        w_nxt     = AR;
        w_nxt_tgt = HG;
      end
      PW: if ((w_t == WALK_LAST) || emg) begin
        w_nxt     = AR;
        w_nxt_tgt = HG;
      end
      default: w_nxt = HG;
    endcase
    w_restart = (w_nxt != r_state);
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      r_state    <= HG;
      r_tgt      <= HG;
      r_ped_wait <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_tgt   <= w_nxt_tgt;
      // Entering WALK serves the request; that clear outranks a same-edge press.
      if ((w_nxt == PW) && (r_state != PW)) begin
        r_ped_wait <= 1'b0;
      end else if (ped_req && (r_state != PW)) begin
        r_ped_wait <= 1'b1;
      end
    end
  end

  assign hwy      = hwy_lamp(r_state);
  assign cntry    = cntry_lamp(r_state);
  assign walk     = (r_state == PW);
  assign ped_wait = r_ped_wait;
  assign phase    = r_state;

endmodule
